// File: rtl/shift_pkg.sv
// Shared types and constants for the parallel-to-serial transmitter.
// Holds the FSM state encoding, the default word width and the counter-width helper.
package shift_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter width for a 0..w-1 range; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Saturating 0..WIDTH-1 bit counter with clear > load > increment priority.
// Next-cycle update; no handshake, last_o flags the final count.
module shift_bit_counter
    import shift_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_WIDTH,
    localparam int CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o
);

    localparam logic [CW-1:0] MAX = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = (load_val_i > MAX) ? MAX : load_val_i;
        end else if (inc_i && (cnt_q != MAX)) begin
            // Holds at MAX rather than wrapping.
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == MAX);

endmodule

// File: rtl/shift_tx.sv
// Parallel-to-serial transmitter: first bit on q one cycle after acceptance, WIDTH bits per frame.
// Backpressure: in_ready only in IDLE or on the last-bit cycle, so back-to-back frames run gap-free.
module shift_tx
    import shift_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             q,
    output logic             q_valid,
    output logic             q_first,
    output logic             done
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             q_q, q_d;
    logic             q_valid_q, q_valid_d;
    logic             q_first_q, q_first_d;
    logic             done_q, done_d;

    logic             cnt_clr;
    logic             cnt_load;
    logic             cnt_inc;
    logic [CW-1:0]    cnt;
    logic             cnt_last;
    logic             accept;

    shift_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i ('0),
        .inc_i      (cnt_inc),
        .cnt_o      (cnt),
        .last_o     (cnt_last)
    );

    assign in_ready = (state_q == IDLE) || ((state_q == SHIFT) && cnt_last);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        q_d       = 1'b0;
        q_valid_d = 1'b0;
        q_first_d = 1'b0;
        done_d    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;

        if (accept) begin
            // The first bit goes straight from in_data so it appears one cycle after acceptance.
            state_d   = SHIFT;
            sreg_d    = in_data;
            q_d       = (MSB_FIRST != 0) ? in_data[WIDTH-1] : in_data[0];
            q_valid_d = 1'b1;
            q_first_d = 1'b1;
            cnt_load  = 1'b1;
        end else if (state_q == SHIFT) begin
            if (cnt_last) begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end else begin
                // sreg keeps the word aligned so the bit on q is always at the outgoing end.
                if (MSB_FIRST != 0) begin
                    q_d    = sreg_q[WIDTH-2];
                    sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                end else begin
                    q_d    = sreg_q[1];
                    sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
                end
                q_valid_d = 1'b1;
                done_d    = (cnt == PRE_LAST);
                cnt_inc   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            q_q       <= 1'b0;
            q_valid_q <= 1'b0;
            q_first_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            q_first_q <= q_first_d;
            done_q    <= done_d;
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign q_first = q_first_q;
    assign done    = done_q;

endmodule

// File: tb/tb_shift_tx.sv
// Bench for shift_tx: MSB-first and LSB-first instances share stimulus; a queue-based scoreboard checks every output cycle.
module tb_shift_tx;
    import shift_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] in_data;

    logic rdy_m, q_m, qv_m, qf_m, dn_m;
    logic rdy_l, q_l, qv_l, qf_l, dn_l;

    int tot = 0;
    int bad = 0;

    // Each entry is {q, q_first, done} expected on one valid output cycle.
    logic [2:0] exp_m[$];
    logic [2:0] exp_l[$];

    always #5 clk = ~clk;

    shift_tx #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_m), .q(q_m), .q_valid(qv_m), .q_first(qf_m), .done(dn_m)
    );

    shift_tx #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_l), .q(q_l), .q_valid(qv_l), .q_first(qf_l), .done(dn_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            exp_m.push_back({w[W-1-i], i == 0, i == W-1});
            exp_l.push_back({w[i], i == 0, i == W-1});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One word from idle; in_data is scrambled right after acceptance.
    task automatic send_one(input logic [W-1:0] w);
        in_data  = w;
        in_valid = 1'b1;
        push_frame(w);
        step();
        in_valid = 1'b0;
        in_data  = ~w;
        for (int i = 1; i <= W; i++) begin
            chk("busy_ready_m", rdy_m, i == W);
            chk("busy_ready_l", rdy_l, i == W);
            step();
        end
        chk("idle_ready_m", rdy_m, 1);
        chk("idle_valid_m", qv_m, 0);
    endtask

    // Scoreboard monitors, sampling on the falling edge.
    always @(negedge clk) begin
        if (qv_m) begin
            if (exp_m.size() == 0) begin
                tot++;
                bad++;
                $display("FAIL m_unexpected: q_valid=1 with nothing expected at %0t", $time);
            end else begin
                chk("m_q_first_done", {q_m, qf_m, dn_m}, exp_m.pop_front());
            end
        end else begin
            chk("m_idle_outputs", {q_m, qf_m, dn_m}, 0);
        end
    end

    always @(negedge clk) begin
        if (qv_l) begin
            if (exp_l.size() == 0) begin
                tot++;
                bad++;
                $display("FAIL l_unexpected: q_valid=1 with nothing expected at %0t", $time);
            end else begin
                chk("l_q_first_done", {q_l, qf_l, dn_l}, exp_l.pop_front());
            end
        end else begin
            chk("l_idle_outputs", {q_l, qf_l, dn_l}, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) step();
        chk("rst_q_valid", qv_m, 0);
        chk("rst_q", q_m, 0);
        chk("rst_first_done", {qf_m, dn_m}, 0);
        reset = 1'b0;
        #1;
        chk("rst_ready_m", rdy_m, 1);
        chk("rst_ready_l", rdy_l, 1);

        // Single words: 0xA5 and 0x01 through both bit orders.
        send_one(8'hA5);
        send_one(8'h01);

        // Back-to-back 0xFF then 0x00 with in_valid held high.
        in_data  = 8'hFF;
        in_valid = 1'b1;
        push_frame(8'hFF);
        step();
        in_data = 8'h00;
        push_frame(8'h00);
        for (int i = 1; i <= 2 * W; i++) begin
            if (i == W + 1) in_valid = 1'b0;
            chk("b2b_valid_m", qv_m, 1);
            chk("b2b_valid_l", qv_l, 1);
            chk("b2b_ready", rdy_m, (i == W) || (i == 2 * W));
            step();
        end
        chk("b2b_end_valid", qv_m, 0);

        // in_valid held with changing data mid-frame; the word offered on the last-bit cycle is taken.
        in_data  = 8'h96;
        in_valid = 1'b1;
        push_frame(8'h96);
        step();
        for (int i = 1; i <= W; i++) begin
            if (i == W) begin
                in_data = 8'h3C;
                push_frame(8'h3C);
            end else begin
                in_data = 8'($urandom);
            end
            chk("hold_ready", rdy_m, i == W);
            step();
        end
        in_valid = 1'b0;
        for (int i = 1; i <= W; i++) begin
            chk("tail_ready", rdy_m, i == W);
            step();
        end

        // Reset during cycle 4 of a 0xC3 frame aborts it; 0x81 follows cleanly.
        in_data  = 8'hC3;
        in_valid = 1'b1;
        push_frame(8'hC3);
        step();
        in_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        exp_m.delete();
        exp_l.delete();
        chk("abort_valid_m", qv_m, 0);
        chk("abort_done_m", dn_m, 0);
        chk("abort_valid_l", qv_l, 0);
        reset = 1'b0;
        #1;
        chk("abort_ready", rdy_m, 1);
        send_one(8'h81);

        // Reset wins over a simultaneous in_valid.
        in_data  = 8'hFF;
        in_valid = 1'b1;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rv_outputs", {q_m, qv_m, qf_m, dn_m}, 0);
        chk("rv_ready", rdy_m, 1);
        step();
        chk("rv_no_accept_m", qv_m, 0);
        chk("rv_no_accept_l", qv_l, 0);

        repeat (3) step();
        chk("leftover_m", exp_m.size(), 0);
        chk("leftover_l", exp_l.size(), 0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule

// File: doc/shift_tx.md
SHIFT_TX -- requirements
Module: shift_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of bits per parallel word (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 means serialize bit WIDTH-1 first and 0 means serialize bit 0 first.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data holds a word to send.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: the parallel word.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 The block SHALL have port q, output, 1 bit: registered serial data.
REQ-009 The block SHALL have port q_valid, output, 1 bit: q carries a valid bit.
REQ-010 The block SHALL have port q_first, output, 1 bit: q carries bit 0 of a frame (the first serialized bit).
REQ-011 The block SHALL have port done, output, 1 bit: q carries the last bit of a frame.

Function
REQ-012 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_data SHALL be captured into an internal WIDTH-bit shift register on that edge.
REQ-013 The state machine SHALL have two states, IDLE and SHIFT:
- IDLE to SHIFT on acceptance.
- SHIFT to IDLE after the last bit, unless a new word is accepted on that same edge.
REQ-014 in_ready SHALL be combinational and equal to 1 when the state is IDLE, or when the state is SHIFT and the bit counter equals WIDTH-1 (last-bit cycle); it SHALL be 0 otherwise.
REQ-015 The first bit of an accepted word SHALL appear on q, with q_valid=1 and q_first=1, in the cycle immediately after the accepting edge (latency 1).
REQ-016 Successive bits SHALL follow on consecutive cycles with no gaps.
- A frame SHALL occupy exactly WIDTH cycles of q_valid=1.
- Order SHALL be MSB-first when MSB_FIRST=1, LSB-first otherwise.
REQ-017 The bit counter SHALL be $clog2(WIDTH) bits wide, SHALL hold 0 on the first bit, SHALL increment by 1 per bit, and SHALL reload to 0 on acceptance; it SHALL never exceed WIDTH-1.
REQ-018 done SHALL be 1 exactly in the cycle where the counter equals WIDTH-1 and q_valid=1; q_first and done SHALL never be 1 in the same cycle.
REQ-019 Back-to-back: if a word is accepted during the last-bit cycle, its first bit SHALL appear in the next cycle with q_first=1, and q_valid SHALL stay 1 continuously.
REQ-020 In IDLE, q, q_valid, q_first and done SHALL all be 0.
REQ-021 in_data and in_valid SHALL be ignored while in_ready=0; they SHALL NOT affect the frame in flight.
REQ-022 Changes to in_data after acceptance SHALL NOT affect the bits being sent.

Reset
REQ-023 While reset=1 at a rising edge, the state SHALL become IDLE and the counter and shift register SHALL become 0.
REQ-024 After a reset edge, q, q_valid, q_first and done SHALL all be 0, and in_ready SHALL be 1 once reset deasserts.
REQ-025 Reset SHALL take priority over a simultaneous in_valid=1; that word SHALL NOT be accepted.
REQ-026 Reset asserted mid-frame SHALL abort the frame: q_valid SHALL be 0 from the next cycle, and no done pulse SHALL be produced for the aborted word.

Structure
REQ-027 A shared package shift_pkg SHALL hold:
- the state type (IDLE, SHIFT);
- the default WIDTH constant.
REQ-028 The design SHALL use one sub-module, shift_bit_counter, a wrap-free 0..WIDTH-1 counter with synchronous clear, load and increment enable, and a last-count flag output.
REQ-029 All outputs except in_ready SHALL be driven directly from flip-flops.

Verification
REQ-030 Single word, WIDTH=8, MSB_FIRST=1, in_data=0xA5: q SHALL be 1,0,1,0,0,1,0,1 on cycles 1..8 after acceptance; q_first=1 on cycle 1 only; done=1 on cycle 8 only.
REQ-031 Same word with MSB_FIRST=0: q SHALL be 1,0,1,0,0,1,0,1 reversed, i.e. 1,0,1,0,0,1,0,1 read from bit 0 upward; use 0x01 to distinguish: q=1,0,0,0,0,0,0,0.
REQ-032 Back-to-back 0xFF then 0x00 with in_valid held high: q_valid=1 for 16 consecutive cycles; q=1 for 8 cycles, then 0 for 8 cycles; q_first=1 on cycles 1 and 9.
REQ-033 Hold in_valid=1 with a changing in_data during a frame: in_ready=0 on cycles 1..7, and q SHALL reflect only the first captured word.
REQ-034 Reset at cycle 4 of a 0xC3 frame: q_valid=0 from cycle 5, no done, and a following 0x81 is sent correctly starting one cycle after acceptance.
REQ-035 reset=1 and in_valid=1 on the same edge: no acceptance, and all outputs 0 on the next cycle.
